// File: rtl/pipeline_trace_buffer.sv
// Trace capture for the 5-stage CPU: circular buffer of {PC, selected bus} that
// freezes POST samples after a PC-match trigger and exposes a registered read port.
module pipeline_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int POST  = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          arm,
  input  logic          abort,
  input  logic [31:0]   trig_pc,
  input  logic [2:0]    sel,
  input  logic [31:0]   PC,
  input  logic [31:0]   IF_Inst,
  input  logic [31:0]   ID_Inst,
  input  logic [31:0]   EXE_Alu,
  input  logic [31:0]   MEM_Alu,
  input  logic [31:0]   WB_Alu,
  output logic [1:0]    state,
  output logic          done,
  output logic [AW:0]   count,
  output logic [AW-1:0] trig_pos,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_data
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_ARMED     = 2'b01,
    S_TRIGGERED = 2'b10,
    S_DONE      = 2'b11
  } state_t;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   POST_W  = (AW+1)'(POST);
  localparam logic [AW-1:0] POST_C  = AW'(POST);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   post_cnt_q, post_cnt_d;
  logic [AW-1:0]   trig_pos_q, trig_pos_d;
  logic [31:0]     rd_pc_q, rd_pc_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic            wr_en, clear, load_tp;
  logic [31:0]     mux_data;
  logic [AW:0]     tp_full;
  logic [AW-1:0]   rd_phys;
  logic [63:0]     rd_entry;
  logic [63:0]     mem_q [DEPTH];

  always_comb begin
    mux_data = '0;
    case (sel)
      3'd0:    mux_data = IF_Inst;
      3'd1:    mux_data = ID_Inst;
      3'd2:    mux_data = EXE_Alu;
      3'd3:    mux_data = MEM_Alu;
      3'd4:    mux_data = WB_Alu;
      default: mux_data = '0;
    endcase
  end

  // abort wins over arm and suppresses the write of its own cycle.
  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    wr_en      = 1'b0;
    clear      = 1'b0;
    load_tp    = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d = S_ARMED;
            clear   = 1'b1;
          end
        end
        S_ARMED: begin
          wr_en = 1'b1;
          if (PC == trig_pc) begin
            if (POST == 0) begin
              state_d = S_DONE;
              load_tp = 1'b1;
            end else begin
              state_d    = S_TRIGGERED;
              post_cnt_d = POST_C;
            end
          end
        end
        S_TRIGGERED: begin
          wr_en      = 1'b1;
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) begin
            state_d = S_DONE;
            load_tp = 1'b1;
          end
        end
        S_DONE: begin
          if (arm) begin
            state_d = S_ARMED;
            clear   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q != DEPTH_C) count_d = count_q + (AW+1)'(1);
    end
    // Uses the count including the sample written on the DONE edge.
    tp_full    = count_d - (AW+1)'(1) - POST_W;
    trig_pos_d = load_tp ? tp_full[AW-1:0] : trig_pos_q;
  end

  // Window start is wr_ptr - count; pre-edge pointers give old-entry read semantics.
  always_comb begin
    rd_phys   = wr_ptr_q - count_q[AW-1:0] + rd_addr;
    rd_entry  = mem_q[rd_phys];
    rd_pc_d   = '0;
    rd_data_d = '0;
    if ({1'b0, rd_addr} < count_q) begin
      rd_pc_d   = rd_entry[63:32];
      rd_data_d = rd_entry[31:0];
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      trig_pos_q <= '0;
      rd_pc_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      trig_pos_q <= trig_pos_d;
      rd_pc_q    <= rd_pc_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= {PC, mux_data};
  end

  assign state    = state_q;
  assign done     = (state_q == S_DONE);
  assign count    = count_q;
  assign trig_pos = trig_pos_q;
  assign rd_pc    = rd_pc_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer: one POST=4 instance and one POST=0
// instance fed from the same CPU buses, expected values computed by hand.
module tb_pipeline_trace_buffer;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [31:0] PC, IF_Inst, ID_Inst, EXE_Alu, MEM_Alu, WB_Alu;

  logic        a_arm, a_abort, b_arm, b_abort;
  logic [31:0] a_trig_pc, b_trig_pc;
  logic [2:0]  a_sel, b_sel;
  logic [3:0]  a_rd_addr, b_rd_addr;
  logic [1:0]  a_state, b_state;
  logic        a_done, b_done;
  logic [4:0]  a_count, b_count;
  logic [3:0]  a_trig_pos, b_trig_pos;
  logic [31:0] a_rd_pc, a_rd_data, b_rd_pc, b_rd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] r_pc, r_data;
  logic [2:0]  sel_tab [5];
  logic [31:0] dat_tab [5];

  always #5 Clock = ~Clock;

  pipeline_trace_buffer #(.DEPTH(16), .AW(4), .POST(4)) u_a (
    .Clock(Clock), .Resetn(Resetn), .arm(a_arm), .abort(a_abort),
    .trig_pc(a_trig_pc), .sel(a_sel), .PC(PC), .IF_Inst(IF_Inst),
    .ID_Inst(ID_Inst), .EXE_Alu(EXE_Alu), .MEM_Alu(MEM_Alu), .WB_Alu(WB_Alu),
    .state(a_state), .done(a_done), .count(a_count), .trig_pos(a_trig_pos),
    .rd_addr(a_rd_addr), .rd_pc(a_rd_pc), .rd_data(a_rd_data)
  );

  pipeline_trace_buffer #(.DEPTH(16), .AW(4), .POST(0)) u_b (
    .Clock(Clock), .Resetn(Resetn), .arm(b_arm), .abort(b_abort),
    .trig_pc(b_trig_pc), .sel(b_sel), .PC(PC), .IF_Inst(IF_Inst),
    .ID_Inst(ID_Inst), .EXE_Alu(EXE_Alu), .MEM_Alu(MEM_Alu), .WB_Alu(WB_Alu),
    .state(b_state), .done(b_done), .count(b_count), .trig_pos(b_trig_pos),
    .rd_addr(b_rd_addr), .rd_pc(b_rd_pc), .rd_data(b_rd_data)
  );

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pc(input logic [31:0] pc);
    PC      = pc;
    IF_Inst = 32'h5000_0000 | pc;
    ID_Inst = 32'h2000_0000 | pc;
    EXE_Alu = 32'h3000_0000 | pc;
    MEM_Alu = 32'h4000_0000 | pc;
    WB_Alu  = pc + 32'h1000;
  endtask

  task automatic read_a(input logic [3:0] addr, output logic [31:0] pc, output logic [31:0] dat);
    a_rd_addr = addr;
    tick();
    pc  = a_rd_pc;
    dat = a_rd_data;
  endtask

  initial begin
    sel_tab[0] = 3'd1; dat_tab[0] = 32'h2000_0000;
    sel_tab[1] = 3'd2; dat_tab[1] = 32'h3000_0004;
    sel_tab[2] = 3'd3; dat_tab[2] = 32'h4000_0008;
    sel_tab[3] = 3'd6; dat_tab[3] = 32'h0000_0000;
    sel_tab[4] = 3'd4; dat_tab[4] = 32'h0000_1010;

    Resetn = 1'b0;
    a_arm = 0; a_abort = 0; a_trig_pc = 0; a_sel = 0; a_rd_addr = 0;
    b_arm = 0; b_abort = 0; b_trig_pc = 0; b_sel = 0; b_rd_addr = 0;
    drive_pc(32'h0);
    #12;
    chk("rst_state", a_state, 2'b00);
    chk("rst_done", a_done, 1'b0);
    chk("rst_count", a_count, 5'd0);
    chk("rst_trig_pos", a_trig_pos, 4'd0);
    chk("rst_rd_pc", a_rd_pc, 32'h0);
    chk("rst_rd_data", a_rd_data, 32'h0);
    chk("rst_b_state", b_state, 2'b00);
    @(negedge Clock);
    Resetn = 1'b1;
    tick();

    // T1: async reset in the middle of TRIGGERED
    a_trig_pc = 32'h8; a_sel = 3'd0; a_rd_addr = 4'd1;
    a_arm = 1; drive_pc(32'h99); tick(); a_arm = 0;
    chk("t1_armed", a_state, 2'b01);
    for (int i = 0; i < 4; i++) begin
      drive_pc(32'(4 * i));
      tick();
      if (i == 2) chk("t1_trig_state", a_state, 2'b10);
    end
    chk("t1_pre_state", a_state, 2'b10);
    chk("t1_pre_count", a_count, 5'd4);
    chk("t1_window_pc", a_rd_pc, 32'h4);
    chk("t1_window_data", a_rd_data, 32'h5000_0004);
    Resetn = 1'b0;
    #1;
    chk("t1_rst_state", a_state, 2'b00);
    chk("t1_rst_count", a_count, 5'd0);
    chk("t1_rst_done", a_done, 1'b0);
    chk("t1_rst_rd_pc", a_rd_pc, 32'h0);
    chk("t1_rst_rd_data", a_rd_data, 32'h0);
    a_rd_addr = 4'd0;
    @(negedge Clock);
    Resetn = 1'b1;
    tick();

    // T2: wrap with trigger at 0x40
    a_trig_pc = 32'h40; a_arm = 1; drive_pc(32'h99); tick(); a_arm = 0;
    chk("t2_armed", a_state, 2'b01);
    for (int i = 0; i < 21; i++) begin
      drive_pc(32'(4 * i));
      tick();
      if (i == 16) chk("t2_triggered", a_state, 2'b10);
      if (i == 19) chk("t2_not_done_yet", a_done, 1'b0);
    end
    chk("t2_state", a_state, 2'b11);
    chk("t2_done", a_done, 1'b1);
    chk("t2_count", a_count, 5'd16);
    chk("t2_trig_pos", a_trig_pos, 4'd11);
    drive_pc(32'h54); tick(); tick();
    chk("t2_hold_count", a_count, 5'd16);
    read_a(4'd0, r_pc, r_data);
    chk("t2_rd0_pc", r_pc, 32'h14);
    chk("t2_rd0_data", r_data, 32'h5000_0014);
    read_a(4'd11, r_pc, r_data);
    chk("t2_rd11_pc", r_pc, 32'h40);
    read_a(4'd15, r_pc, r_data);
    chk("t2_rd15_pc", r_pc, 32'h50);

    // T3: early trigger, re-arm from DONE, WB source
    a_trig_pc = 32'h8; a_sel = 3'd4; a_arm = 1; drive_pc(32'h77); tick(); a_arm = 0;
    chk("t3_rearm_state", a_state, 2'b01);
    chk("t3_rearm_count", a_count, 5'd0);
    for (int i = 0; i < 7; i++) begin
      drive_pc(32'(4 * i));
      tick();
    end
    chk("t3_state", a_state, 2'b11);
    chk("t3_count", a_count, 5'd7);
    chk("t3_trig_pos", a_trig_pos, 4'd2);
    read_a(4'd2, r_pc, r_data);
    chk("t3_rd2_pc", r_pc, 32'h8);
    chk("t3_rd2_data", r_data, 32'h1008);
    read_a(4'd7, r_pc, r_data);
    chk("t3_rd7_pc", r_pc, 32'h0);
    chk("t3_rd7_data", r_data, 32'h0);
    read_a(4'd6, r_pc, r_data);
    chk("t3_rd6_pc", r_pc, 32'h18);
    read_a(4'd0, r_pc, r_data);
    chk("t3_rd0_data", r_data, 32'h1000);

    // T4: per-cycle source select, including an out-of-range select
    a_trig_pc = 32'h0; a_arm = 1; drive_pc(32'h99); tick(); a_arm = 0;
    for (int i = 0; i < 5; i++) begin
      drive_pc(32'(4 * i));
      IF_Inst = 32'h0;
      a_sel = sel_tab[i];
      tick();
    end
    chk("t4_state", a_state, 2'b11);
    chk("t4_count", a_count, 5'd5);
    chk("t4_trig_pos", a_trig_pos, 4'd0);
    for (int i = 0; i < 5; i++) begin
      read_a(4'(i), r_pc, r_data);
      chk("t4_rd_pc", r_pc, 64'(4 * i));
      chk("t4_rd_data", r_data, dat_tab[i]);
    end

    // T5: abort after 3 post-trigger samples
    a_sel = 3'd0; a_trig_pc = 32'h8; a_arm = 1; drive_pc(32'h99); tick(); a_arm = 0;
    for (int i = 0; i < 6; i++) begin
      drive_pc(32'(4 * i));
      tick();
    end
    chk("t5_pre_abort_state", a_state, 2'b10);
    a_abort = 1; drive_pc(32'h18); tick(); a_abort = 0;
    chk("t5_abort_state", a_state, 2'b00);
    chk("t5_abort_count", a_count, 5'd6);
    for (int i = 0; i < 3; i++) begin
      drive_pc(32'h8);
      tick();
    end
    chk("t5_ignore_state", a_state, 2'b00);
    chk("t5_ignore_count", a_count, 5'd6);
    a_arm = 1; a_abort = 1; tick(); a_arm = 0; a_abort = 0;
    chk("t5_arm_abort_state", a_state, 2'b00);
    read_a(4'd5, r_pc, r_data);
    chk("t5_rd5_pc", r_pc, 32'h14);
    read_a(4'd6, r_pc, r_data);
    chk("t5_rd6_pc", r_pc, 32'h0);

    // T6: POST=0 instance, immediate DONE and re-arm
    b_trig_pc = 32'hC; b_arm = 1; drive_pc(32'h99); tick(); b_arm = 0;
    chk("t6_armed", b_state, 2'b01);
    for (int i = 0; i < 4; i++) begin
      drive_pc(32'(4 * i));
      tick();
      if (i == 2) chk("t6_still_armed", b_state, 2'b01);
    end
    chk("t6_state", b_state, 2'b11);
    chk("t6_done", b_done, 1'b1);
    chk("t6_count", b_count, 5'd4);
    chk("t6_trig_pos", b_trig_pos, 4'd3);
    drive_pc(32'h10); tick();
    chk("t6_hold_count", b_count, 5'd4);
    b_rd_addr = 4'd3; tick();
    chk("t6_rd3_pc", b_rd_pc, 32'hC);
    b_arm = 1; tick(); b_arm = 0;
    chk("t6_rearm_state", b_state, 2'b01);
    chk("t6_rearm_count", b_count, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
